// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the BCD stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2
    } sw_state_e;

    localparam int unsigned UnitsMax = 9;
    localparam int unsigned TensMax  = 5;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit with synchronous clear and a same-cycle carry for cascading.
module bcd_digit_counter #(
    parameter int unsigned MAX = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] value,
    output logic       carry
);

    logic [3:0] value_q, value_d;

    assign carry = inc && (value_q == 4'(MAX));
    assign value = value_q;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = 4'd0;
        end else if (inc) begin
            value_d = (value_q == 4'(MAX)) ? 4'd0 : value_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch with start/stop/clear control and a tick prescaler.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic       running,
    output logic       wrap
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    sw_state_e state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic wrap_q;
    logic qual_tick, step;
    logic c_sec_lo, c_sec_hi, c_min_lo, c_min_hi;

    // A tick only counts in RUN when no stop/clear arrives in the same cycle.
    assign qual_tick = (state_q == StRun) && tick && !stop && !clear;
    assign step      = qual_tick && (presc_q == PW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start) state_d = StRun;
                StRun:   if (stop) state_d = StPause;
                StPause: if (!stop && start) state_d = StRun;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        running = (state_q == StRun);
        wrap    = wrap_q;
    end

    always_comb begin
        presc_d = presc_q;
        if (clear) begin
            presc_d = '0;
        end else if (qual_tick) begin
            presc_d = step ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            wrap_q  <= c_min_hi && !clear;
        end
    end

    bcd_digit_counter #(.MAX(UnitsMax)) u_sec_lo (
        .clk(clk), .reset(reset), .inc(step), .clr(clear), .value(sec_lo), .carry(c_sec_lo)
    );
    bcd_digit_counter #(.MAX(TensMax)) u_sec_hi (
        .clk(clk), .reset(reset), .inc(c_sec_lo), .clr(clear), .value(sec_hi), .carry(c_sec_hi)
    );
    bcd_digit_counter #(.MAX(UnitsMax)) u_min_lo (
        .clk(clk), .reset(reset), .inc(c_sec_hi), .clr(clear), .value(min_lo), .carry(c_min_lo)
    );
    bcd_digit_counter #(.MAX(TensMax)) u_min_hi (
        .clk(clk), .reset(reset), .inc(c_min_lo), .clr(clear), .value(min_hi), .carry(c_min_hi)
    );

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed self-checking bench for stopwatch_bcd with DIV=4.
module tb_stopwatch_bcd;

    logic clk = 1'b0;
    logic reset = 1'b0, tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
    logic running, wrap;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stopwatch_bcd #(.DIV(4)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop), .clear(clear),
        .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
        .running(running), .wrap(wrap)
    );

    function automatic logic [15:0] mmss();
        return {min_hi, min_lo, sec_hi, sec_lo};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, sample #1 after the edge, then idle the inputs.
    task automatic cyc(input logic t, input logic st, input logic sp, input logic cl,
                       input logic rs);
        tick = t; start = st; stop = sp; clear = cl; reset = rs;
        @(posedge clk);
        #1;
        tick = 0; start = 0; stop = 0; clear = 0; reset = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
    endtask

    task automatic restart();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0);
    endtask

    initial begin
        #2;
        // Reset state
        cyc(1, 1, 0, 0, 1);
        check_eq("rst_time", 32'(mmss()), 32'h0000);
        check_eq("rst_running", 32'(running), 0);
        check_eq("rst_wrap", 32'(wrap), 0);

        // Start, 8 ticks -> 00:02, prescaler back at 0
        cyc(0, 1, 0, 0, 0);
        check_eq("start_running", 32'(running), 1);
        ticks(8);
        check_eq("run8_time", 32'(mmss()), 32'h0002);
        ticks(3);
        check_eq("presc0_hold", 32'(mmss()), 32'h0002);
        ticks(1);
        check_eq("presc0_inc", 32'(mmss()), 32'h0003);

        // Pause keeps prescaler and digits
        restart();
        ticks(6);
        check_eq("pre_pause", 32'(mmss()), 32'h0001);
        cyc(1, 0, 1, 0, 0);
        check_eq("pause_running", 32'(running), 0);
        ticks(10);
        check_eq("paused_time", 32'(mmss()), 32'h0001);
        cyc(0, 1, 0, 0, 0);
        check_eq("resume_running", 32'(running), 1);
        ticks(1);
        check_eq("resume_1tick", 32'(mmss()), 32'h0001);
        ticks(1);
        check_eq("resume_2tick", 32'(mmss()), 32'h0002);

        // Count to 59:58, then roll over
        restart();
        ticks(3598 * 4);
        check_eq("preload_5958", 32'(mmss()), 32'h5958);
        ticks(4);
        check_eq("at_5959", 32'(mmss()), 32'h5959);
        check_eq("no_wrap_5959", 32'(wrap), 0);
        ticks(3);
        check_eq("hold_5959", 32'(mmss()), 32'h5959);
        ticks(1);
        check_eq("rolled_0000", 32'(mmss()), 32'h0000);
        check_eq("wrap_pulse", 32'(wrap), 1);
        check_eq("wrap_running", 32'(running), 1);
        cyc(0, 0, 0, 0, 0);
        check_eq("wrap_one_cycle", 32'(wrap), 0);
        check_eq("after_wrap_running", 32'(running), 1);

        // Clear beats a terminal tick at 59:59
        restart();
        ticks(3599 * 4 + 3);
        check_eq("pre_clear_5959", 32'(mmss()), 32'h5959);
        cyc(1, 0, 0, 1, 0);
        check_eq("clear_time", 32'(mmss()), 32'h0000);
        check_eq("clear_running", 32'(running), 0);
        check_eq("clear_wrap", 32'(wrap), 0);
        cyc(0, 0, 0, 0, 0);
        check_eq("clear_wrap_next", 32'(wrap), 0);

        // start+stop in PAUSE stays paused; stop in IDLE stays idle
        restart();
        ticks(4);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        check_eq("pause_both_running", 32'(running), 0);
        ticks(8);
        check_eq("pause_both_time", 32'(mmss()), 32'h0001);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        check_eq("idle_stop_running", 32'(running), 0);
        ticks(4);
        check_eq("idle_tick_time", 32'(mmss()), 32'h0000);

        // Reset dominates start and tick mid-count
        restart();
        ticks(36);
        check_eq("pre_reset_0009", 32'(mmss()), 32'h0009);
        cyc(1, 1, 0, 0, 1);
        check_eq("reset_time", 32'(mmss()), 32'h0000);
        check_eq("reset_running", 32'(running), 0);
        check_eq("reset_wrap", 32'(wrap), 0);
        ticks(4);
        check_eq("reset_idle_time", 32'(mmss()), 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
